// File: rtl/expand_rr_sched_if.sv
// expand_rr_sched_if: requester/consumer bundle for the shared EXPAND scheduler.
// master = requesters + result consumer, slave = scheduler.
// Optional stats signals exist only when EXPAND_RR_SCHED_STATS_EN is defined.
interface expand_rr_sched_if #(
    parameter int NCH = 4,
    parameter int IDW = 2
);
    logic [NCH-1:0]   req;
    logic [8*NCH-1:0] sin_bus;
    logic [NCH-1:0]   law_bus;
    logic [NCH-1:0]   gnt;
    logic [13:0]      sout;
    logic [IDW-1:0]   chan;
    logic             valid;
    logic             ack;
    logic             busy;
`ifdef EXPAND_RR_SCHED_STATS_EN
    logic [15:0]      conv_cnt;
    logic             stall;

    modport master (output req, sin_bus, law_bus, ack,
                    input  gnt, sout, chan, valid, busy, conv_cnt, stall);
    modport slave  (input  req, sin_bus, law_bus, ack,
                    output gnt, sout, chan, valid, busy, conv_cnt, stall);
`else
    modport master (output req, sin_bus, law_bus, ack,
                    input  gnt, sout, chan, valid, busy);
    modport slave  (input  req, sin_bus, law_bus, ack,
                    output gnt, sout, chan, valid, busy);
`endif
endinterface

// File: rtl/expand_rr_sched.sv
// expand_rr_sched: round-robin scheduler sharing one A-law/u-law -> 14-bit
// uniform PCM expander among NCH requesters. One result per 3 cycles at best:
// grant (IDLE) -> expand (CONV) -> hold result until ACK (RESP).
// Optional feature macro: EXPAND_RR_SCHED_STATS_EN adds conv_cnt / stall.
// NCH <= 2**IDW is required by the caller.

// Combinational G.711 expander, output is 14-bit two's complement.
// A-law magnitude is the 13-bit value scaled by 2 to share the u-law range.
module expand_rr_core (
    input  logic [7:0]  code,
    input  logic        law,
    output logic [13:0] pcm
);
    logic [7:0]  um, ax;
    logic [13:0] umag, amag, mag;
    logic [6:0]  abase;

    // decode magnitude for both laws and apply sign from code bit 7
    always_comb begin
        um    = ~code;
        umag  = ({8'd0, 1'b1, um[3:0], 1'b1} << um[6:4]) - 14'd33;
        ax    = code ^ 8'h55;
        abase = {(ax[6:4] != 3'd0), ax[3:0], 2'b10};
        amag  = (ax[6:4] > 3'd1) ? ({7'd0, abase} << (ax[6:4] - 3'd1))
                                 : {7'd0, abase};
        mag   = law ? amag : umag;
        pcm   = code[7] ? mag : (14'd0 - mag);
    end
endmodule

module expand_rr_sched #(
    parameter int NCH = 4,
    parameter int IDW = 2
) (
    input logic               clk,
    input logic               reset,
    expand_rr_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [7:0]     cap_sin;
    logic           cap_law;
    logic [IDW-1:0] cap_id;
    logic [13:0]    sout_q;
    logic [IDW-1:0] chan_q;
    logic           valid_q;
    logic           busy_q;

    logic           win_vld;
    logic [IDW-1:0] win_id;
    logic [IDW:0]   cand;
    logic [IDW-1:0] ptr_nxt;
    logic [NCH-1:0] gnt_c;
    logic [13:0]    exp_pcm;

    // first requester at or after ptr, wrapping modulo NCH
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NCH))
                cand = cand - (IDW+1)'(NCH);
            if (!win_vld && bus.req[cand[IDW-1:0]]) begin
                win_vld = 1'b1;
                win_id  = cand[IDW-1:0];
            end
        end
    end

    // grant pulse only in IDLE and never while reset is asserted
    always_comb begin
        gnt_c = '0;
        if (state == IDLE && !reset && win_vld)
            gnt_c[win_id] = 1'b1;
    end

    assign ptr_nxt = (win_id == IDW'(NCH-1)) ? '0 : win_id + 1'b1;

    // the shared expander only ever sees the capture registers
    expand_rr_core u_exp (
        .code (cap_sin),
        .law  (cap_law),
        .pcm  (exp_pcm)
    );

    // scheduler FSM: capture on grant, register result, hold until ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            cap_sin <= '0;
            cap_law <= 1'b0;
            cap_id  <= '0;
            sout_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        cap_sin <= bus.sin_bus[8*win_id +: 8];
                        cap_law <= bus.law_bus[win_id];
                        cap_id  <= win_id;
                        ptr     <= ptr_nxt;
                        busy_q  <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    sout_q  <= exp_pcm;
                    chan_q  <= cap_id;
                    valid_q <= 1'b1;
                    state   <= RESP;
                end
                RESP: begin
                    if (bus.ack) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_c;
    assign bus.sout  = sout_q;
    assign bus.chan  = chan_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

`ifdef EXPAND_RR_SCHED_STATS_EN
    logic [15:0] conv_cnt_q;

    // completed-transfer counter, saturating at all ones
    always_ff @(posedge clk) begin
        if (reset)
            conv_cnt_q <= '0;
        else if (valid_q && bus.ack && conv_cnt_q != 16'hFFFF)
            conv_cnt_q <= conv_cnt_q + 16'd1;
    end

    assign bus.conv_cnt = conv_cnt_q;
    assign bus.stall    = (state == RESP) && !bus.ack;
`endif
endmodule
